// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: scan-code set 2 prefix decoder,
// key-event FIFO, receiver frame gating and sticky error flags.
module ps2_rx_ctrl #(
    parameter int FIFO_DEPTH = 8,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ctrl_en,
    input  logic          rx_done_tick,
    input  logic [7:0]    rx_data,
    output logic          rx_en,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [9:0]    ev_data,
    output logic [CW-1:0] ev_count,
    output logic          overflow,
    output logic          kbd_err,
    input  logic          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_BASE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t state;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          accept;
    logic          b_ext;
    logic          b_brk;
    logic          b_err;
    logic          b_code;
    logic          cur_ext;
    logic          cur_brk;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;

    // Byte classification and push/pop arbitration.
    always_comb begin
        b_ext  = 1'b0;
        b_brk  = 1'b0;
        b_err  = 1'b0;
        b_code = 1'b0;
        case (rx_data)
            8'hE0:        b_ext  = 1'b1;
            8'hF0:        b_brk  = 1'b1;
            8'h00, 8'hFF: b_err  = 1'b1;
            default:      b_code = 1'b1;
        endcase

        accept   = rx_done_tick & ctrl_en;
        cur_ext  = (state == S_EXT) || (state == S_EXT_BRK);
        cur_brk  = (state == S_BRK) || (state == S_EXT_BRK);
        full     = (count == DEPTH_C);
        pop      = ev_valid & ev_ready;
        push_req = accept & b_code;
        // A full FIFO can still take a push when the head leaves this cycle.
        push_ok  = push_req & (~full | pop);

        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Prefix decoder: E0/F0 latch modifiers, any other byte ends the sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BASE;
        end else if (!ctrl_en) begin
            state <= S_BASE;
        end else if (rx_done_tick) begin
            if (b_ext) begin
                state <= S_EXT;
            end else if (b_brk) begin
                state <= cur_ext ? S_EXT_BRK : S_BRK;
            end else begin
                state <= S_BASE;
            end
        end
    end

    // Event storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {cur_brk, cur_ext, rx_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Receiver permission follows ctrl_en and drops with the filling push.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_en <= 1'b0;
        end else begin
            rx_en <= ctrl_en & (count_next < DEPTH_C);
        end
    end

    // Sticky flags; a set event in the clear cycle keeps the flag high.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            kbd_err  <= 1'b0;
        end else begin
            overflow <= (push_req & ~push_ok) | (overflow & ~err_clr);
            kbd_err  <= (accept & b_err) | (kbd_err & ~err_clr);
        end
    end

    assign ev_valid = (count != '0);
    assign ev_count = count;
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

endmodule
